// File: rtl/popcount09_pkg.sv
// rtl/popcount09_pkg.sv - shared constants, state type and vector helpers for the weight-k enumerator
package popcount09_pkg;

  localparam int N     = 9;
  localparam int CNT_W = 4;
  localparam int IDX_W = 7;

  localparam logic [CNT_W-1:0] K_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Smallest N-bit value of weight kk: the kk low bits set.
  function automatic logic [N-1:0] first_vec(input logic [CNT_W-1:0] kk);
    return N'((10'(1) << kk) - 10'(1));
  endfunction

  // Largest N-bit value of weight kk: the kk high bits set.
  function automatic logic [N-1:0] last_vec(input logic [CNT_W-1:0] kk);
    return first_vec(kk) << (4'(N) - kk);
  endfunction

endpackage

// File: rtl/popcount09_vecgen_if.sv
// rtl/popcount09_vecgen_if.sv - output vector stream with valid/ready handshake
import popcount09_pkg::*;

interface popcount09_vecgen_if;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_vec;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    output out_vec,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_vec,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/popcount09_comb_next.sv
// rtl/popcount09_comb_next.sv - next larger 9-bit value with the same popcount (Gosper step)
import popcount09_pkg::*;

module popcount09_comb_next (
  input  logic [N-1:0] v,
  output logic [N-1:0] nxt
);

  logic [N-1:0]     c;
  logic [N:0]       r;
  logic [CNT_W-1:0] tz;
  logic [4:0]       sh;
  logic [N-1:0]     spread;

  // Trailing-zero count; an all-zero input yields N so the shift clears everything.
  always_comb begin
    tz = CNT_W'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) tz = CNT_W'(i);
    end
  end

  assign c      = v & (~v + N'(1));
  assign r      = {1'b0, v} + {1'b0, c};
  assign sh     = {1'b0, tz} + 5'd2;
  assign spread = N'((r ^ {1'b0, v}) >> sh);
  assign nxt    = r[N-1:0] | spread;

endmodule

// File: rtl/popcount09_vecgen.sv
// rtl/popcount09_vecgen.sv - enumerates every 9-bit vector of weight k in ascending order
import popcount09_pkg::*;

module popcount09_vecgen (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    k,
  output logic                busy,
  output logic                err,
  popcount09_vecgen_if.master vec
);

  state_t           state, state_nxt;
  logic [N-1:0]     vec_q, vec_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [CNT_W-1:0] k_q, k_nxt;
  logic             err_q, err_nxt;
  logic [N-1:0]     succ;
  logic             is_last;
  logic             xfer;

  popcount09_comb_next u_next (
    .v   (vec_q),
    .nxt (succ)
  );

  // Valid/last are derived from state so that reset leaves them low without extra flops.
  assign busy          = (state == RUN);
  assign vec.out_valid = busy;
  assign vec.out_vec   = vec_q;
  assign vec.out_idx   = idx_q;
  assign is_last       = busy && (vec_q == last_vec(k_q));
  assign vec.out_last  = is_last;
  assign xfer          = busy && vec.out_ready;
  assign err           = err_q;

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    idx_nxt   = idx_q;
    k_nxt     = k_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k > K_MAX) begin
            err_nxt = 1'b1;
          end else begin
            vec_nxt   = first_vec(k);
            idx_nxt   = '0;
            k_nxt     = k;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (is_last) begin
            state_nxt = IDLE;
          end else begin
            vec_nxt = succ;
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec_q <= '0;
      idx_q <= '0;
      k_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      vec_q <= vec_nxt;
      idx_q <= idx_nxt;
      k_q   <= k_nxt;
      err_q <= err_nxt;
    end
  end

endmodule

// File: tb/tb_popcount09_vecgen.sv
// tb/tb_popcount09_vecgen.sv - directed bench with an enumeration model checked every cycle
module tb_popcount09_vecgen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] k = 4'd0;
  logic       busy;
  logic       err;

  popcount09_vecgen_if vif ();

  popcount09_vecgen dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k     (k),
    .busy  (busy),
    .err   (err),
    .vec   (vif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         pos = 0;
  int         emitted = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: all 9-bit values of weight kk in ascending numeric order.
  task automatic build_model(input int kk);
    logic [8:0] v9;
    exp_q.delete();
    got_q.delete();
    for (int v = 0; v < 512; v++) begin
      v9 = v[8:0];
      if ($countones(v9) == kk) exp_q.push_back(v9);
    end
    pos = 0;
    emitted = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vif.out_valid) begin
        if (pos >= exp_q.size()) begin
          check("extra_vec", pos, exp_q.size() - 1);
        end else begin
          check("vec", int'(vif.out_vec), int'(exp_q[pos]));
          check("idx", int'(vif.out_idx), pos);
          check("last", int'(vif.out_last), int'(pos == exp_q.size() - 1));
        end
        if (vif.out_ready) begin
          got_q.push_back(vif.out_vec);
          pos++;
          emitted++;
        end
      end
      if (busy !== vif.out_valid) check("busy_eq_valid", int'(busy), int'(vif.out_valid));
      if (busy && err) check("err_in_run", int'(err), 0);
    end
  end

  task automatic pulse_start(input logic [3:0] kk);
    @(posedge clk); #1;
    start = 1'b1;
    k = kk;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_k(input int kk, input bit rand_ready, input bit restart_mid,
                       input int exp_count, input string name);
    int cyc;
    build_model(kk);
    vif.out_ready = 1'b1;
    pulse_start(4'(kk));
    check({name, "_first_valid"}, int'(vif.out_valid), 1);
    cyc = 0;
    while (busy && cyc < 4000) begin
      vif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (restart_mid && (cyc == 10 || cyc == 11)) ? 1'b1 : 1'b0;
      k = 4'd3;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    vif.out_ready = 1'b1;
    check({name, "_timeout"}, int'(cyc >= 4000), 0);
    check({name, "_count"}, emitted, exp_count);
    check({name, "_valid_drop"}, int'(vif.out_valid), 0);
  endtask

  initial begin
    vif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(vif.out_valid), 0);
    check("rst_vec", int'(vif.out_vec), 0);
    check("rst_idx", int'(vif.out_idx), 0);
    check("rst_last", int'(vif.out_last), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;

    build_model(2);
    check("model_k2_size", exp_q.size(), 36);
    check("model_k2_0", int'(exp_q[0]), 9'b000000011);
    check("model_k2_1", int'(exp_q[1]), 9'b000000101);
    check("model_k2_2", int'(exp_q[2]), 9'b000000110);
    check("model_k2_35", int'(exp_q[35]), 9'b110000000);

    run_k(0, 1'b0, 1'b0, 1, "k0");
    check("k0_vec", int'(got_q[0]), 0);

    run_k(2, 1'b0, 1'b0, 36, "k2");
    check("k2_got0", int'(got_q[0]), 9'b000000011);
    check("k2_got1", int'(got_q[1]), 9'b000000101);
    check("k2_got2", int'(got_q[2]), 9'b000000110);
    check("k2_got35", int'(got_q[35]), 9'b110000000);

    build_model(10);
    pulse_start(4'd10);
    check("k10_err", int'(err), 1);
    check("k10_valid", int'(vif.out_valid), 0);
    check("k10_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("k10_err_drop", int'(err), 0);
    check("k10_busy2", int'(busy), 0);

    run_k(4, 1'b1, 1'b0, 126, "k4");
    run_k(3, 1'b0, 1'b1, 84, "k3_restart");

    begin
      int cyc;
      build_model(5);
      pulse_start(4'd5);
      cyc = 0;
      while (vif.out_idx != 7'd20 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("k5_reach20", int'(vif.out_idx), 20);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("k5_rst_valid", int'(vif.out_valid), 0);
      check("k5_rst_busy", int'(busy), 0);
      check("k5_rst_vec", int'(vif.out_vec), 0);
      check("k5_rst_idx", int'(vif.out_idx), 0);
      check("k5_rst_last", int'(vif.out_last), 0);
      check("k5_emitted", emitted, 20);
    end

    run_k(9, 1'b0, 1'b0, 1, "k9");
    check("k9_vec", int'(got_q[0]), 9'b111111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
